// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    localparam logic [N_REQ-1:0] GNT_BIT0 = 8'h01;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod 8.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] rot_s;
    logic [SEL_W-1:0] pos_s;
    logic             any_s;

    // Rotate so that bit 0 of rot_s is the requester at ptr.
    always_comb begin
        rot_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rot_s[k] = req[ptr + SEL_W'(k)];
        end
    end

    // Lowest set bit of the rotated vector; scanning downward leaves the lowest.
    always_comb begin
        pos_s = '0;
        any_s = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                pos_s = SEL_W'(k);
                any_s = 1'b1;
            end else begin
                pos_s = pos_s;
            end
        end
    end

    assign any = any_s;
    assign idx = ptr + pos_s;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbiter for an 8:1 mux with multi-beat hold and optional
// forced rotation after MAX_HOLD accepted beats.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic             preempt
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic             preempt_q, preempt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             pick_any_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             accept_s;
    logic             owner_req_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             hold_hit_s;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    assign accept_s    = out_valid_q & out_ready;
    assign owner_req_s = req[sel_q];
    assign cnt_inc_s   = (accept_s && (beat_cnt_q != CNT_MAX)) ? (beat_cnt_q + CNT_ONE) : beat_cnt_q;
    assign hold_hit_s  = (MAX_HOLD != 0) && accept_s && (cnt_inc_s == HOLD_LIM);

    // Next-state and next-output computation for the IDLE/GRANT controller.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        preempt_d   = 1'b0;
        ptr_d       = ptr_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d     = GRANT;
                    gnt_d       = GNT_BIT0 << pick_idx_s;
                    sel_d       = pick_idx_s;
                    out_valid_d = 1'b1;
                    beat_cnt_d  = '0;
                end else begin
                    gnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            end
            GRANT: begin
                // A coinciding voluntary drop wins over preemption, so preempt needs req still high.
                if (!owner_req_s || hold_hit_s) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    out_valid_d = 1'b0;
                    ptr_d       = sel_q + 3'd1;
                    preempt_d   = hold_hit_s & owner_req_s;
                    beat_cnt_d  = cnt_inc_s;
                end else begin
                    beat_cnt_d  = cnt_inc_s;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            ptr_q       <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            preempt_q   <= preempt_d;
            ptr_q       <= ptr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign preempt   = preempt_q;

endmodule
